// File: rtl/pad_pkg.sv
// Shared definitions for the NES gamepad reader: FSM state encoding,
// button bit positions within the decoded frame, and the frame width.
package pad_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    // Number of serial bits in one pad frame
    localparam int PAD_BITS = 8;

    // Bit positions in the decoded, active-high button vector
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs.
// RESET_VAL selects the value both flops take under reset, so a
// pulled-up line reads as "released" straight out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so each flop takes the other's pre-edge value;
            // blocking here would collapse the chain into a single flop.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/nes_pad_reader.sv
// NES-style serial gamepad reader. On a poll request from IDLE it drives
// the latch/clock protocol, shifts in 8 active-low button bits and presents
// them as a registered active-high vector with a one-cycle valid strobe.
// Optional build macro: NES_PAD_DEBOUNCE_EN -- buttons update only when two
// consecutive frames agree.
module nes_pad_reader
    import pad_pkg::*;
#(
    parameter int HALF = 150
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                poll,
    input  logic                pad_data,
    output logic                pad_latch,
    output logic                pad_clk,
    output logic [PAD_BITS-1:0] buttons,
    output logic                valid,
    output logic                busy
);

    // The latch phase lasts two half periods; the 10-bit counter covers one
    // half period and the bit index tracks which half of LATCH is running.
    localparam logic [9:0] CNT_RELOAD = 10'(HALF - 1);
    localparam logic [2:0] LAST_IDX   = 3'(PAD_BITS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [9:0]          r_cnt;
    logic [2:0]          r_idx;
    logic [PAD_BITS-1:0] r_shift;
    logic [PAD_BITS-1:0] r_buttons;
    logic                r_pad_latch;
    logic                r_pad_clk;
    logic                r_valid;
    logic                r_busy;
    logic                w_pad_sync;
    logic                w_d_s;
    logic                w_phase_end;
    logic                w_sample;
    logic                w_frame_done;
`ifdef NES_PAD_DEBOUNCE_EN
    logic [PAD_BITS-1:0] r_raw;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_pad_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pad_data),
        .o_q (w_pad_sync)
    );

    // Pad line is active-low; d_s is 1 when the current button is pressed
    assign w_d_s       = ~w_pad_sync;
    assign w_phase_end = (r_cnt == 10'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the sample / frame-complete strobes
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (poll) w_next_state = LATCH;
            end
            LATCH: begin
                if (w_phase_end && r_idx[0]) w_next_state = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (w_phase_end) begin
                    w_sample     = 1'b1;
                    w_next_state = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_phase_end) begin
                    if (r_idx == LAST_IDX) begin
                        w_frame_done = 1'b1;
                        w_next_state = DONE;
                    end else begin
                        w_next_state = SHIFT_LO;
                    end
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Phase counter and bit index; the counter reloads at every phase boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_RELOAD;
            r_idx <= 3'd0;
        end else begin
            if (r_state == IDLE || r_state == DONE || w_phase_end) begin
                r_cnt <= CNT_RELOAD;
            end else begin
                r_cnt <= r_cnt - 10'd1;
            end

            if (r_state == IDLE) begin
                r_idx <= 3'd0;
            end else if (r_state == LATCH && w_phase_end) begin
                // First half ends -> mark second half; second half ends -> bit 0
                r_idx <= {2'b00, ~r_idx[0]};
            end else if (r_state == SHIFT_HI && w_phase_end) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // Shift capture, button load and registered protocol/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_buttons   <= '0;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
            r_raw       <= '0;
`endif
        end else begin
            if (w_sample) r_shift[r_idx] <= w_d_s;

            // Load on the edge entering DONE so buttons and valid appear together
            if (w_frame_done) begin
`ifdef NES_PAD_DEBOUNCE_EN
                if (r_shift == r_raw) r_buttons <= r_shift;
                r_raw <= r_shift;
`else
                r_buttons <= r_shift;
`endif
            end

            r_pad_latch <= (w_next_state == LATCH);
            r_pad_clk   <= (w_next_state == SHIFT_HI);
            r_valid     <= (w_next_state == DONE);
            r_busy      <= (w_next_state == LATCH) || (w_next_state == SHIFT_LO) ||
                           (w_next_state == SHIFT_HI);
        end
    end

    assign pad_latch = r_pad_latch;
    assign pad_clk   = r_pad_clk;
    assign buttons   = r_buttons;
    assign valid     = r_valid;
    assign busy      = r_busy;

endmodule
